alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 190 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready request and result handshake.
// Single-cycle ops land in HOLD one cycle after acceptance. The iterative
// shift-add multiplier (op 13) is present only when ALU_PIPE_MUL_EN is
// defined; otherwise op 13 reports illegal_op like op 15.
//
// state | meaning
// IDLE  | no result held, ready for a request
// MUL   | shift-add multiply in progress, one multiplier bit per cycle
// HOLD  | result presented on y/flags with out_valid, waiting for out_ready
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             zero_flag,
  output logic             overflow_flag,
  output logic             illegal_op,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
`ifdef ALU_PIPE_MUL_EN
    , MUL = 2'd2
`endif
  } state_t;

  state_t state, state_nxt, accept_state;
  logic   accept;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   diff;
  logic [SW-1:0]      rot_amt;
  logic [2*WIDTH-1:0] rol_ext;
  logic [2*WIDTH-1:0] ror_ext;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;
  logic               alu_v;
  logic               alu_ill;

  assign in_ready  = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign diff    = a - b;
  assign rot_amt = b[SW-1:0];
  assign rol_ext = {a, a} << rot_amt;
  assign ror_ext = {a, a} >> rot_amt;

  // Single-cycle result and flags for the op presented at the input.
  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      4'd0:  alu_y = a | b;
      4'd1:  alu_y = a & b;
      4'd2:  alu_y = ~(a & b);
      4'd3:  alu_y = ~(a | b);
      4'd4:  alu_y = ~a;
      4'd5:  alu_y = a ^ b;
      4'd6: begin
        alu_y = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7: begin
        alu_y = diff;
        alu_c = (a >= b);
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd8:  alu_y = (b >= WIDTH_V) ? '0 : (a << b);
      4'd9:  alu_y = (b >= WIDTH_V) ? '0 : (a >> b);
      4'd10: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd11: alu_y = rol_ext[2*WIDTH-1:WIDTH];
      4'd12: alu_y = ror_ext[WIDTH-1:0];
      4'd13: begin
`ifndef ALU_PIPE_MUL_EN
        alu_ill = 1'b1;
`endif
      end
      4'd14: alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic [SW-1:0]      mul_cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               mul_start;
  logic               mul_done;

  assign mul_start = accept && (op == 4'd13);
  assign mul_done  = (state == MUL) && (mul_cnt == '0);
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

  // Shift-add datapath; down-counter marks the last multiplier bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (mul_start) begin
      mul_cnt <= SW'(WIDTH - 1);
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - 1'b1;
      end
    end
  end

  assign accept_state = (op == 4'd13) ? MUL : HOLD;
`else
  assign accept_state = HOLD;
`endif

  // Next-state selection; a transfer with a new request skips IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = accept_state;
      HOLD: if (out_ready) state_nxt = accept ? accept_state : IDLE;
`ifdef ALU_PIPE_MUL_EN
      MUL:  if (mul_cnt == '0) state_nxt = HOLD;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result register: loaded on a single-cycle accept or multiply completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      y             <= '0;
      carry_flag    <= 1'b0;
      neg_flag      <= 1'b0;
      zero_flag     <= 1'b0;
      overflow_flag <= 1'b0;
      illegal_op    <= 1'b0;
    end else if (accept && (accept_state == HOLD)) begin
      y             <= alu_y;
      carry_flag    <= alu_c;
      neg_flag      <= alu_y[WIDTH-1];
      zero_flag     <= (alu_y == '0);
      overflow_flag <= alu_v;
      illegal_op    <= alu_ill;
    end
`ifdef ALU_PIPE_MUL_EN
    else if (mul_done) begin
      y             <= acc_nxt[WIDTH-1:0];
      carry_flag    <= (acc_nxt[2*WIDTH-1:WIDTH] != '0);
      neg_flag      <= acc_nxt[WIDTH-1];
      zero_flag     <= (acc_nxt[WIDTH-1:0] == '0);
      overflow_flag <= 1'b0;
      illegal_op    <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed vector table,
// hand-written handshake/reset sequences, and randomized ops against a model.
module tb_alu_pipe;
  localparam int W = 32;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a, b;
  logic [3:0]    op;
  logic          in_valid, in_ready;
  logic [W-1:0]  y;
  logic          carry_flag, neg_flag, zero_flag, overflow_flag, illegal_op;
  logic          out_valid, out_ready;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .carry_flag(carry_flag), .neg_flag(neg_flag), .zero_flag(zero_flag),
    .overflow_flag(overflow_flag), .illegal_op(illegal_op),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [31:0] y;
    logic c, n, z, v, ill;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    res_t        exp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  vec_t vq[$];

  function automatic res_t mk(logic [31:0] ry, logic c, logic n, logic z, logic v, logic ill);
    res_t r;
    r.y = ry; r.c = c; r.n = n; r.z = z; r.v = v; r.ill = ill;
    return r;
  endfunction

  // Reference model: plain 64-bit arithmetic on the op definitions.
  function automatic res_t model(logic [3:0] mop, logic [31:0] ma, logic [31:0] mb);
    res_t r;
    longint unsigned ua, ub, full;
    longint sa, sb, sres;
    int ri;
    r = '0;
    ua = {32'h0, ma};
    ub = {32'h0, mb};
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      4'd0: r.y = ma | mb;
      4'd1: r.y = ma & mb;
      4'd2: r.y = ~(ma & mb);
      4'd3: r.y = ~(ma | mb);
      4'd4: r.y = ~ma;
      4'd5: r.y = ma ^ mb;
      4'd6: begin
        full = ua + ub;
        r.y = full[31:0];
        r.c = (full > 64'hFFFF_FFFF);
        sres = sa + sb;
        r.v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd7: begin
        full = ua - ub;
        r.y = full[31:0];
        r.c = (ua >= ub);
        sres = sa - sb;
        r.v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd8: r.y = (ub >= 32) ? 32'h0 : (ma << ub);
      4'd9: r.y = (ub >= 32) ? 32'h0 : (ma >> ub);
      4'd10: r.y = (ua < ub) ? 32'h1 : 32'h0;
      4'd11: begin
        ri = int'(ub % 32);
        r.y = (ri == 0) ? ma : ((ma << ri) | (ma >> (32 - ri)));
      end
      4'd12: begin
        ri = int'(ub % 32);
        r.y = (ri == 0) ? ma : ((ma >> ri) | (ma << (32 - ri)));
      end
      4'd13: begin
        if (MUL_EN) begin
          full = ua * ub;
          r.y = full[31:0];
          r.c = ((full >> 32) != 0);
        end else begin
          r.ill = 1'b1;
        end
      end
      4'd14: r.y = (sa < sb) ? 32'h1 : 32'h0;
      default: r.ill = 1'b1;
    endcase
    r.z = (r.y == 32'h0);
    r.n = r.y[31];
    return r;
  endfunction

  function automatic int exp_latency(logic [3:0] mop);
    return (MUL_EN && mop == 4'd13) ? W + 1 : 1;
  endfunction

  function automatic res_t dut_res();
    return mk(y, carry_flag, neg_flag, zero_flag, overflow_flag, illegal_op);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request with out_ready held high; checks latency, busy in_ready and result.
  task automatic run_op(input string name, input logic [3:0] vop, input logic [31:0] va,
                        input logic [31:0] vb, input res_t exp, input int exp_lat);
    int lat;
    bit busy_ok;
    @(negedge clk);
    a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b1;
    check({name, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, 64'(dut_res()), 64'(exp));
    if (exp_lat > 1) check({name, " in_ready low while busy"}, 64'(busy_ok), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  sop [0:3];
    logic [31:0] sa_v [0:3];
    logic [31:0] sb_v [0:3];
    res_t held;
    bit stable_ok, no_stale;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(dut_res()), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", 64'(in_ready), 64'd1);

    // Directed table: expectations derived by hand
    vq.push_back('{op: 4'd6,  a: 32'hFFFF_FFFF, b: 32'h1,         exp: mk(32'h0,         1, 0, 1, 0, 0)});
    vq.push_back('{op: 4'd7,  a: 32'h8000_0000, b: 32'h1,         exp: mk(32'h7FFF_FFFF, 1, 0, 0, 1, 0)});
    vq.push_back('{op: 4'd14, a: 32'hFFFF_FFFF, b: 32'h1,         exp: mk(32'h1,         0, 0, 0, 0, 0)});
    vq.push_back('{op: 4'd10, a: 32'hFFFF_FFFF, b: 32'h1,         exp: mk(32'h0,         0, 0, 1, 0, 0)});
    vq.push_back('{op: 4'd8,  a: 32'h1,         b: 32'd40,        exp: mk(32'h0,         0, 0, 1, 0, 0)});
    vq.push_back('{op: 4'd11, a: 32'h8000_0001, b: 32'd33,        exp: mk(32'h3,         0, 0, 0, 0, 0)});
    vq.push_back('{op: 4'd12, a: 32'h1,         b: 32'd1,         exp: mk(32'h8000_0000, 0, 1, 0, 0, 0)});
    vq.push_back('{op: 4'd9,  a: 32'h8000_0000, b: 32'd31,        exp: mk(32'h1,         0, 0, 0, 0, 0)});
    vq.push_back('{op: 4'd2,  a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: mk(32'h0,         0, 0, 1, 0, 0)});
    vq.push_back('{op: 4'd6,  a: 32'h7FFF_FFFF, b: 32'h1,         exp: mk(32'h8000_0000, 0, 1, 0, 1, 0)});
    vq.push_back('{op: 4'd7,  a: 32'h1,         b: 32'h2,         exp: mk(32'hFFFF_FFFF, 0, 1, 0, 0, 0)});
    vq.push_back('{op: 4'd15, a: 32'h5,         b: 32'h3,         exp: mk(32'h0,         0, 0, 1, 0, 1)});
    vq.push_back('{op: 4'd5,  a: 32'hF0F0_0000, b: 32'h0FF0_0001, exp: mk(32'hFF00_0001, 0, 1, 0, 0, 0)});
    vq.push_back('{op: 4'd4,  a: 32'hFFFF_0000, b: 32'h0,         exp: mk(32'h0000_FFFF, 0, 0, 0, 0, 0)});
    foreach (vq[i]) begin
      run_op($sformatf("vec%0d op%0d", i, vq[i].op), vq[i].op, vq[i].a, vq[i].b, vq[i].exp, 1);
    end

    // Multiply corner: 0x10000 * 0x10000
    if (MUL_EN)
      run_op("mul 0x10000^2", 4'd13, 32'h1_0000, 32'h1_0000, mk(32'h0, 1, 0, 1, 0, 0), 33);
    else
      run_op("mul disabled", 4'd13, 32'h1_0000, 32'h1_0000, mk(32'h0, 0, 0, 1, 0, 1), 1);

    // Backpressure: result held 5 cycles, then transfer + accept on one edge
    @(negedge clk);
    a = 32'd2; b = 32'd3; op = 4'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    held = dut_res();
    check("stall first result", 64'(held), 64'(mk(32'd5, 0, 0, 0, 0, 0)));
    stable_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || in_ready || dut_res() != held) stable_ok = 1'b0;
    end
    check("stall hold stable", 64'(stable_ok), 64'd1);
    out_ready = 1'b1; in_valid = 1'b1; a = 32'hF0; b = 32'hFF; op = 4'd5;
    #1;
    check("stall release in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall next valid", 64'(out_valid), 64'd1);
    check("stall next result", 64'(dut_res()), 64'(mk(32'h0F, 0, 0, 0, 0, 0)));
    @(negedge clk);
    check("stall drained", 64'(out_valid), 64'd0);

    // Back-to-back single-cycle stream, one result per cycle
    for (int i = 0; i < 4; i++) begin
      sop[i] = 4'($urandom_range(0, 14));
      if (sop[i] == 4'd13) sop[i] = 4'd6;
      sa_v[i] = $urandom;
      sb_v[i] = $urandom_range(0, 40);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    a = sa_v[0]; b = sb_v[0]; op = sop[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stream%0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d result", i), 64'(dut_res()), 64'(model(sop[i], sa_v[i], sb_v[i])));
      if (i < 3) begin
        a = sa_v[i+1]; b = sb_v[i+1]; op = sop[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("stream drained", 64'(out_valid), 64'd0);

    // Reset while a result is held
    a = 32'd1; b = 32'd1; op = 4'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("hold rst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("hold rst out_valid", 64'(out_valid), 64'd0);
    check("hold rst result", 64'(dut_res()), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    no_stale = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) no_stale = 1'b0;
    end
    check("hold rst no stale", 64'(no_stale), 64'd1);

    // Reset on cycle 10 of a multiply
    if (MUL_EN) begin
      @(negedge clk);
      a = 32'd3; b = 32'd5; op = 4'd13; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mul rst out_valid", 64'(out_valid), 64'd0);
      check("mul rst y", 64'(y), 64'd0);
      check("mul rst in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      no_stale = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) no_stale = 1'b0;
      end
      check("mul rst no stale", 64'(no_stale), 64'd1);
      check("mul rst idle", 64'(in_ready), 64'd1);
    end

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : 32'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), exp_latency(rop));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
